// File: rtl/mac_cascade_chain_if.sv
// rtl/mac_cascade_chain_if.sv - sample input and result bus of mac_cascade_chain
interface mac_cascade_chain_if #(
  parameter int NUM_STAGES = 3,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 48
);
  logic                         in_valid;
  logic [NUM_STAGES*DATA_W-1:0] a;
  logic [NUM_STAGES*DATA_W-1:0] b;
  logic [ACC_W-1:0]             c_in;
  logic                         op_sub;
  logic [ACC_W-1:0]             p;
  logic                         out_valid;
  logic [ACC_W-1:0]             pcout;
  logic                         pcout_valid;
  logic                         out_sat;

  modport master (
    output in_valid, a, b, c_in, op_sub,
    input  p, out_valid, pcout, pcout_valid, out_sat
  );

  modport slave (
    input  in_valid, a, b, c_in, op_sub,
    output p, out_valid, pcout, pcout_valid, out_sat
  );
endinterface

// File: rtl/mac_cascade_chain.sv
// rtl/mac_cascade_chain.sv - systolic multiply-add chain p = c_in +/- sum(a_s*b_s)
// Define MAC_CASCADE_SATURATE_EN to clamp each stage at the ACC_W bounds instead of wrapping.
module mac_cascade_chain #(
  parameter int NUM_STAGES = 3,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 48,
  parameter int SIGNED     = 0
) (
  input logic               clk,
  input logic               reset,
  input logic               ce,
  input logic               sclr,
  mac_cascade_chain_if.slave bus
);

  // Returns {overflow, next accumulator} for acc +/- x*y.
  function automatic logic [ACC_W:0] mac_step(
    input logic [ACC_W-1:0]  acc,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic              sub
  );
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    ext;
    logic [ACC_W:0]      acc_x;
    logic [ACC_W:0]      ext_x;
    logic [ACC_W:0]      sum;
    logic                sat;
    if (SIGNED != 0) begin
      prod  = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(y));
      ext   = ACC_W'($signed(prod));
      acc_x = {acc[ACC_W-1], acc};
      ext_x = {ext[ACC_W-1], ext};
    end else begin
      prod  = (2*DATA_W)'(x) * (2*DATA_W)'(y);
      ext   = ACC_W'(prod);
      acc_x = {1'b0, acc};
      ext_x = {1'b0, ext};
    end
    sum = sub ? (acc_x - ext_x) : (acc_x + ext_x);
`ifdef MAC_CASCADE_SATURATE_EN
    // One guard bit is enough: a single add/sub can only overflow by one bound.
    if (SIGNED != 0) begin
      sat = sum[ACC_W] ^ sum[ACC_W-1];
      if (sat)
        sum[ACC_W-1:0] = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat = sum[ACC_W];
      if (sat)
        sum[ACC_W-1:0] = sub ? '0 : '1;
    end
`else
    sat = 1'b0;
`endif
    return {sat, sum[ACC_W-1:0]};
  endfunction

  for (genvar s = 0; s < NUM_STAGES; s++) begin : stg
    logic [ACC_W-1:0]  acc_q;
    logic              vld_q;
    logic              sub_q;
    logic              sat_q;
    logic [ACC_W-1:0]  acc_in;
    logic              vld_in;
    logic              sub_in;
    logic              sat_in;
    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;
    logic [ACC_W:0]    step;

    if (s == 0) begin : g_head
      assign acc_in = bus.c_in;
      assign vld_in = bus.in_valid;
      assign sub_in = bus.op_sub;
      assign sat_in = 1'b0;
      assign a_op   = bus.a[DATA_W-1:0];
      assign b_op   = bus.b[DATA_W-1:0];
    end else begin : g_body
      // s-deep skew so operand s meets its sample at stage s.
      logic [DATA_W-1:0] da [s];
      logic [DATA_W-1:0] db [s];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < s; k++) begin
            da[k] <= '0;
            db[k] <= '0;
          end
        end else if (sclr) begin
          for (int k = 0; k < s; k++) begin
            da[k] <= '0;
            db[k] <= '0;
          end
        end else if (ce) begin
          da[0] <= bus.a[s*DATA_W +: DATA_W];
          db[0] <= bus.b[s*DATA_W +: DATA_W];
          for (int k = 1; k < s; k++) begin
            da[k] <= da[k-1];
            db[k] <= db[k-1];
          end
        end
      end

      assign acc_in = stg[s-1].acc_q;
      assign vld_in = stg[s-1].vld_q;
      assign sub_in = stg[s-1].sub_q;
      assign sat_in = stg[s-1].sat_q;
      assign a_op   = da[s-1];
      assign b_op   = db[s-1];
    end

    assign step = mac_step(acc_in, a_op, b_op, sub_in);

    // Bubbles advance the valid bit but leave the accumulator untouched.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        acc_q <= '0;
        vld_q <= 1'b0;
        sub_q <= 1'b0;
        sat_q <= 1'b0;
      end else if (sclr) begin
        acc_q <= '0;
        vld_q <= 1'b0;
        sub_q <= 1'b0;
        sat_q <= 1'b0;
      end else if (ce) begin
        vld_q <= vld_in;
        if (vld_in) begin
          acc_q <= step[ACC_W-1:0];
          sub_q <= sub_in;
          sat_q <= sat_in | step[ACC_W];
        end
      end
    end
  end

  assign bus.p           = stg[NUM_STAGES-1].acc_q;
  assign bus.out_valid   = stg[NUM_STAGES-1].vld_q;
  assign bus.pcout       = stg[NUM_STAGES-1].acc_q;
  assign bus.pcout_valid = stg[NUM_STAGES-1].vld_q;
  assign bus.out_sat     = stg[NUM_STAGES-1].sat_q;

endmodule

// File: tb/tb_mac_cascade_chain.sv
// tb/tb_mac_cascade_chain.sv - directed bench for mac_cascade_chain with a latency/arithmetic model
module tb_mac_cascade_chain;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b1;
  logic sclr  = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mac_cascade_chain_if #(.NUM_STAGES(3), .DATA_W(16), .ACC_W(48)) bu ();
  mac_cascade_chain_if #(.NUM_STAGES(3), .DATA_W(16), .ACC_W(32)) bs ();

  mac_cascade_chain #(.NUM_STAGES(3), .DATA_W(16), .ACC_W(48), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .ce(ce), .sclr(sclr), .bus(bu)
  );
  mac_cascade_chain #(.NUM_STAGES(3), .DATA_W(16), .ACC_W(32), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .ce(ce), .sclr(sclr), .bus(bs)
  );

  localparam longint UMAX = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Dot product straight from the arithmetic rules, with per-stage clamp or wrap.
  function automatic logic [48:0] model_u(input logic [47:0] c, input logic [47:0] av,
                                          input logic [47:0] bv, input bit sub);
    longint acc;
    longint pr;
    bit     sat;
    acc = longint'(c);
    sat = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pr  = longint'(av[s*16 +: 16]) * longint'(bv[s*16 +: 16]);
      acc = sub ? acc - pr : acc + pr;
`ifdef MAC_CASCADE_SATURATE_EN
      if (acc < 0) begin acc = 0; sat = 1'b1; end
      else if (acc > UMAX) begin acc = UMAX; sat = 1'b1; end
`else
      acc = acc & UMAX;
`endif
    end
    return {sat, acc[47:0]};
  endfunction

  function automatic logic [32:0] model_s(input logic [31:0] c, input logic [47:0] av,
                                          input logic [47:0] bv, input bit sub);
    longint acc;
    longint pr;
    bit     sat;
    acc = longint'($signed(c));
    sat = 1'b0;
    for (int s = 0; s < 3; s++) begin
      pr  = longint'($signed(av[s*16 +: 16])) * longint'($signed(bv[s*16 +: 16]));
      acc = sub ? acc - pr : acc + pr;
`ifdef MAC_CASCADE_SATURATE_EN
      if (acc > SMAX) begin acc = SMAX; sat = 1'b1; end
      else if (acc < SMIN) begin acc = SMIN; sat = 1'b1; end
`else
      acc = longint'($signed(acc[31:0]));
`endif
    end
    return {sat, acc[31:0]};
  endfunction

  // Results emerge NUM_STAGES-1 enabled edges after the accepting edge; p holds across bubbles.
  bit          uv [3];
  logic [48:0] ur [3];
  bit          sv [3];
  logic [32:0] sr [3];
  logic [47:0] ue_p;
  bit          ue_v, ue_sat;
  logic [31:0] se_p;
  bit          se_v, se_sat;

  always @(posedge clk or negedge reset) begin
    if (!reset || sclr) begin
      for (int i = 0; i < 3; i++) begin uv[i] = 1'b0; sv[i] = 1'b0; end
      ue_p = '0; ue_v = 1'b0; ue_sat = 1'b0;
      se_p = '0; se_v = 1'b0; se_sat = 1'b0;
    end else if (ce) begin
      for (int i = 2; i > 0; i--) begin
        uv[i] = uv[i-1]; ur[i] = ur[i-1];
        sv[i] = sv[i-1]; sr[i] = sr[i-1];
      end
      uv[0] = bu.in_valid;
      ur[0] = model_u(bu.c_in, bu.a, bu.b, bu.op_sub);
      sv[0] = bs.in_valid;
      sr[0] = model_s(bs.c_in, bs.a, bs.b, bs.op_sub);
      ue_v = uv[2];
      if (uv[2]) {ue_sat, ue_p} = ur[2];
      se_v = sv[2];
      if (sv[2]) {se_sat, se_p} = sr[2];
    end
  end

  always @(negedge clk) begin
    check("u.out_valid", bu.out_valid, ue_v);
    check("u.p", bu.p, ue_p);
    check("u.pcout", bu.pcout, ue_p);
    check("u.pcout_valid", bu.pcout_valid, ue_v);
    check("u.out_sat", bu.out_sat, ue_sat);
    check("s.out_valid", bs.out_valid, se_v);
    check("s.p", bs.p, se_p);
    check("s.pcout", bs.pcout, se_p);
    check("s.out_sat", bs.out_sat, se_sat);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_u(input logic [15:0] a0, a1, a2, b0, b1, b2,
                         input logic [47:0] c, input bit sub);
    bu.in_valid = 1'b1; bu.a = {a2, a1, a0}; bu.b = {b2, b1, b0};
    bu.c_in = c; bu.op_sub = sub;
  endtask

  task automatic drive_s(input logic [15:0] a0, a1, a2, b0, b1, b2,
                         input logic [31:0] c, input bit sub);
    bs.in_valid = 1'b1; bs.a = {a2, a1, a0}; bs.b = {b2, b1, b0};
    bs.c_in = c; bs.op_sub = sub;
  endtask

  task automatic std_u(input logic [47:0] c, input bit sub);
    drive_u(16'd1, 16'd2, 16'd3, 16'd3, 16'd16, 16'd512, c, sub);
  endtask

  // Called one negedge after the accepting edge; latency counted in negedges from the drive.
  task automatic expect_u(input string nm, input logic [47:0] ep, input bit esat);
    int n = 1;
    while (!bu.out_valid && n < 30) begin tick(); n++; end
    check({nm, " latency"}, n, 3);
    check({nm, " p"}, bu.p, ep);
    check({nm, " pcout"}, bu.pcout, ep);
    check({nm, " out_sat"}, bu.out_sat, esat);
  endtask

  task automatic expect_s(input string nm, input logic [31:0] ep, input bit esat);
    int n = 1;
    while (!bs.out_valid && n < 30) begin tick(); n++; end
    check({nm, " latency"}, n, 3);
    check({nm, " p"}, bs.p, ep);
    check({nm, " out_sat"}, bs.out_sat, esat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int first;
    bu.in_valid = 1'b0; bu.a = '0; bu.b = '0; bu.c_in = '0; bu.op_sub = 1'b0;
    bs.in_valid = 1'b0; bs.a = '0; bs.b = '0; bs.c_in = '0; bs.op_sub = 1'b0;
    repeat (2) tick();
    check("reset p", bu.p, 0);
    check("reset out_valid", bu.out_valid, 0);
    check("reset pcout_valid", bu.pcout_valid, 0);
    check("reset out_sat", bu.out_sat, 0);
    check("reset s.p", bs.p, 0);
    reset = 1'b1;
    repeat (2) tick();

    // single sample, then hold
    std_u(48'd0, 1'b0); tick(); bu.in_valid = 1'b0;
    expect_u("t1", 48'd1571, 1'b0);
    tick();
    check("t1 one pulse", bu.out_valid, 0);
    check("t1 hold p", bu.p, 1571);

    std_u(48'd2000, 1'b1); tick(); bu.in_valid = 1'b0;
    expect_u("t2 sub", 48'd429, 1'b0);
    repeat (2) tick();

    // five back-to-back samples
    for (int k = 0; k < 7; k++) begin
      if (k < 5) std_u(48'(k), 1'b0);
      else bu.in_valid = 1'b0;
      tick();
      if (k >= 2) begin
        check("t2 b2b valid", bu.out_valid, 1);
        check("t2 b2b p", bu.p, 48'(1571 + k - 2));
      end
    end
    repeat (2) tick();

    // stall for 4 edges after E+1; stalled in_valid samples are ignored
    std_u(48'd0, 1'b0); tick(); bu.in_valid = 1'b0;
    pulses = 0; first = 0;
    for (int n = 1; n <= 12; n++) begin
      if (bu.out_valid) begin
        pulses++;
        if (first == 0) begin first = n; check("t3 p", bu.p, 1571); end
      end
      if (n == 2) begin ce = 1'b0; drive_u(16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 48'd777, 1'b0); end
      if (n == 6) begin ce = 1'b1; bu.in_valid = 1'b0; end
      tick();
    end
    check("t3 latency", first, 7);
    check("t3 pulses", pulses, 1);

    // async reset with two samples in flight
    std_u(48'd0, 1'b0); tick(); std_u(48'd1, 1'b0); tick(); bu.in_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("t4 rst p", bu.p, 0);
    check("t4 rst out_valid", bu.out_valid, 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("t4 no stale", bu.out_valid, 0);
    std_u(48'd0, 1'b0); tick(); bu.in_valid = 1'b0;
    expect_u("t4 after rst", 48'd1571, 1'b0);
    repeat (2) tick();

    // sclr with ce low still flushes; the sample offered with it is dropped
    std_u(48'd0, 1'b0); tick(); std_u(48'd1, 1'b0); tick();
    sclr = 1'b1; ce = 1'b0; std_u(48'd5, 1'b0); tick();
    sclr = 1'b0; ce = 1'b1; bu.in_valid = 1'b0;
    check("t4 sclr p", bu.p, 0);
    check("t4 sclr out_valid", bu.out_valid, 0);
    repeat (4) tick();
    check("t4 sclr no stale", bu.out_valid, 0);
    std_u(48'd0, 1'b0); tick(); bu.in_valid = 1'b0;
    expect_u("t4 after sclr", 48'd1571, 1'b0);
    repeat (2) tick();

    // unsigned overflow at the top of the accumulator
    drive_u(16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 48'hFFFF_FFFF_FFFF, 1'b0); tick(); bu.in_valid = 1'b0;
`ifdef MAC_CASCADE_SATURATE_EN
    expect_u("u ovf", 48'hFFFF_FFFF_FFFF, 1'b1);
`else
    expect_u("u ovf", 48'h0, 1'b0);
`endif
    repeat (2) tick();

    // signed instance
    drive_s(16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 32'h7FFF_FFFF, 1'b0); tick(); bs.in_valid = 1'b0;
`ifdef MAC_CASCADE_SATURATE_EN
    expect_s("t5 pos ovf", 32'h7FFF_FFFF, 1'b1);
`else
    expect_s("t5 pos ovf", 32'h8000_0000, 1'b0);
`endif
    repeat (2) tick();
    drive_s(16'd1, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 32'h8000_0000, 1'b1); tick(); bs.in_valid = 1'b0;
`ifdef MAC_CASCADE_SATURATE_EN
    expect_s("t5 neg ovf", 32'h8000_0000, 1'b1);
`else
    expect_s("t5 neg ovf", 32'h7FFF_FFFF, 1'b0);
`endif
    repeat (2) tick();
    drive_s(-16'sd2, 16'sd3, -16'sd1, 16'sd5, -16'sd4, -16'sd7, 32'd0, 1'b0); tick(); bs.in_valid = 1'b0;
    expect_s("t6 signed", 32'hFFFF_FFF1, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
